// File: rtl/pixel_counter.sv
// pixel_counter: raster-order (x, y) position counter for the pixel-count pipe.
// Holds the coordinate currently being resolved and advances it on a resolve
// pulse, a sequencer request or (optionally) a background-pixel timeout, and
// emits registered line / frame completion pulses.
//
// Build option: define PIXCNT_TIMEOUT_EN to build the timeout counter that
// auto-advances unresolved pixels and reports them on bgPixel. Without it,
// bgPixel is tied low and the counter waits indefinitely for a request.
module pixel_counter #(
    parameter int H_PIXELS       = 1280,
    parameter int V_PIXELS       = 720,
    parameter int COORD_W        = 11,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               gpuClock,
    input  logic               gpuReset,
    input  logic               frameStart,
    input  logic               pixelIncForce,
    input  logic               pixelInc,
    output logic [COORD_W-1:0] xPixel_pixelCnt,
    output logic [COORD_W-1:0] yPixel_pixelCnt,
    output logic               scanActive,
    output logic               lineDone,
    output logic               frameDone,
    output logic               bgPixel
);

    // ------------------------------------------------------------------
    // Parameter sanity: coordinates must be able to hold the last pixel.
    // ------------------------------------------------------------------
    localparam bit PARAMS_OK = (COORD_W >= 1) && (COORD_W <= 31) &&
                               (H_PIXELS >= 1) && (V_PIXELS >= 1) &&
                               (TIMEOUT_CYCLES >= 1) &&
                               ((1 << COORD_W) >= H_PIXELS) &&
                               ((1 << COORD_W) >= V_PIXELS);

    if (!PARAMS_OK) begin : g_bad_params
        $error("pixel_counter: COORD_W too small for H_PIXELS/V_PIXELS, or a size parameter is zero");
    end

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_PIXELS - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_PIXELS - 1);
    localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic               armed_q, armed_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               line_q, line_d;
    logic               frame_q, frame_d;

    logic timeout_req;   // timeout counter has expired this cycle
    logic run;           // scanning a frame
    logic advance;       // an advance is taken at this edge
    logic x_wrap;        // current pixel is the last of its line
    logic y_wrap;        // current line is the last of the frame

    assign run     = (state_q == ST_RUN);
    // Coincident sources collapse into one request, so they give one advance.
    // armed_q drops for one cycle after each advance, which spaces advances at
    // least two cycles apart and discards a resolve pulse that the upstream
    // controller computed against the coordinate we just left.
    assign advance = run && armed_q && (pixelInc | pixelIncForce | timeout_req);
    assign x_wrap  = (x_q == X_LAST);
    assign y_wrap  = (y_q == Y_LAST);

    // Next-state logic for the scan FSM, coordinates and completion pulses.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        armed_d = !advance;
        line_d  = 1'b0;
        frame_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Requests are ignored here; only frameStart leaves IDLE.
                if (frameStart) begin
                    state_d = ST_RUN;
                    x_d     = '0;
                    y_d     = '0;
                end
            end

            ST_RUN: begin
                // frameStart is deliberately ignored while a frame is running.
                if (advance) begin
                    if (!x_wrap) begin
                        x_d = x_q + COORD_ONE;
                    end else begin
                        x_d    = '0;
                        line_d = 1'b1;
                        if (!y_wrap) begin
                            y_d = y_q + COORD_ONE;
                        end else begin
                            y_d     = '0;
                            frame_d = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scan FSM, arm flag, coordinates and registered pulse outputs.
    always_ff @(posedge gpuClock) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (gpuReset) begin
            state_q <= ST_IDLE;
            armed_q <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            x_q     <= x_d;
            y_q     <= y_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

`ifdef PIXCNT_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Background-pixel timeout: a pixel that sees no request for
    // TIMEOUT_CYCLES cycles is advanced anyway and flagged on bgPixel.
    // ------------------------------------------------------------------
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             bg_q, bg_d;

    assign timeout_req = run && (tmo_q == TMO_LAST);

    // Timeout count: cleared in IDLE and on every advance, otherwise counts
    // up and parks at its terminal value until the advance is taken.
    always_comb begin
        tmo_d = tmo_q;
        if (!run || advance) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_LAST) begin
            tmo_d = tmo_q + TMO_ONE;
        end
        // Only a pure timeout advance counts as a background pixel.
        bg_d = advance && timeout_req && !pixelInc && !pixelIncForce;
    end

    // Timeout counter and registered background-pixel pulse.
    always_ff @(posedge gpuClock) begin
        if (gpuReset) begin
            tmo_q <= '0;
            bg_q  <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            bg_q  <= bg_d;
        end
    end

    assign bgPixel = bg_q;
`else
    // No timeout hardware: the counter advances only on explicit requests.
    assign timeout_req = 1'b0;
    assign bgPixel     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs (all straight from flops)
    // ------------------------------------------------------------------
    assign xPixel_pixelCnt = x_q;
    assign yPixel_pixelCnt = y_q;
    assign scanActive      = run;
    assign lineDone        = line_q;
    assign frameDone       = frame_q;

endmodule
